// File: rtl/sha3_pkg.sv
// ============================================================================
// sha3_pkg: shared Keccak-f[1600] lane types, rho offsets and pi mapping
// Revision: 1.0
// ============================================================================
`default_nettype none

package sha3_pkg;

  localparam int NUM_ROUNDS = 24;

  typedef logic [63:0] lane_t;
  typedef lane_t [4:0] row_t;    // element [x] of one row y
  typedef row_t  [4:0] state_t;  // indexed [y][x]

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] elem;
  } pi_pos_t;

  // Indexed [x][y]
  localparam int RHO_OFFSET [5][5] = '{
    '{ 0, 36,  3, 41, 18},
    '{ 1, 44, 10, 45,  2},
    '{62,  6, 43, 15, 61},
    '{28, 55, 25, 21, 56},
    '{27, 20, 39,  8, 14}
  };

  // Lane (x,y) lands in row (2x+3y) mod 5, element y
  function automatic pi_pos_t pi_dest(input int x, input int y);
    pi_pos_t p;
    p.row  = 3'((2 * x + 3 * y) % 5);
    p.elem = 3'(y);
    return p;
  endfunction

  function automatic lane_t rotl(input lane_t v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha3_theta_columns.sv
// ============================================================================
// sha3_theta_columns: Keccak theta column parities C and correction terms D
// Revision: 1.0
// ============================================================================
`default_nettype none

module sha3_theta_columns
  import sha3_pkg::*;
(
  input  state_t a,
  output row_t   d
);

  row_t c;

  always_comb begin
    c = '0;
    d = '0;
    for (int x = 0; x < 5; x++) begin
      c[x] = a[0][x] ^ a[1][x] ^ a[2][x] ^ a[3][x] ^ a[4][x];
    end
    for (int x = 0; x < 5; x++) begin
      d[x] = c[(x + 4) % 5] ^ rotl(c[(x + 1) % 5], 1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sha3_generic_round_first_half.sv
// ============================================================================
// sha3_generic_round_first_half: pipelined theta/rho/pi half of a Keccak round
// Revision: 1.0
// ============================================================================
`default_nettype none

module sha3_generic_round_first_half
  import sha3_pkg::*;
#(
  parameter int INPUT_BUFFER  = 0,
  parameter int OUTPUT_BUFFER = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] round_index,
  input  row_t       isa,
  input  row_t       isb,
  input  row_t       isc,
  input  row_t       isd,
  input  row_t       ise,
  input  logic       sample,
  output row_t       osa,
  output row_t       osb,
  output row_t       osc,
  output row_t       osd,
  output row_t       ose,
  output logic [4:0] oround,
  output logic       ogood
);

  state_t     in_state;
  state_t     s0_state;
  logic [4:0] s0_round;
  logic       s0_valid;

  assign in_state = {ise, isd, isc, isb, isa};

  generate
    if (INPUT_BUFFER != 0) begin : g_in_buf
      state_t     in_state_q, in_state_d;
      logic [4:0] in_round_q, in_round_d;
      logic       in_valid_q, in_valid_d;

      always_comb begin
        in_valid_d = sample;
        in_state_d = in_state_q;
        in_round_d = in_round_q;
        if (sample) begin
          in_state_d = in_state;
          in_round_d = round_index;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          in_valid_q <= 1'b0;
          in_state_q <= '0;
          in_round_q <= '0;
        end else begin
          in_valid_q <= in_valid_d;
          in_state_q <= in_state_d;
          in_round_q <= in_round_d;
        end
      end

      assign s0_state = in_state_q;
      assign s0_round = in_round_q;
      assign s0_valid = in_valid_q;
    end else begin : g_in_pass
      assign s0_state = in_state;
      assign s0_round = round_index;
      assign s0_valid = sample;
    end
  endgenerate

  // Theta-column register: D terms plus an untouched copy of the lanes
  row_t theta_d;

  sha3_theta_columns u_theta (
    .a (s0_state),
    .d (theta_d)
  );

  row_t       d_q, d_d;
  state_t     lanes_q, lanes_d;
  logic [4:0] round_q, round_d;
  logic       valid_q, valid_d;

  always_comb begin
    valid_d = s0_valid;
    d_d     = d_q;
    lanes_d = lanes_q;
    round_d = round_q;
    if (s0_valid) begin
      d_d     = theta_d;
      lanes_d = s0_state;
      round_d = s0_round;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      d_q     <= '0;
      lanes_q <= '0;
      round_q <= '0;
    end else begin
      valid_q <= valid_d;
      d_q     <= d_d;
      lanes_q <= lanes_d;
      round_q <= round_d;
    end
  end

  // Theta apply, rho rotation and pi permutation are pure wiring
  lane_t  pi_lane [5][5];
  state_t pi_state;

  generate
    for (genvar y = 0; y < 5; y++) begin : g_row
      for (genvar x = 0; x < 5; x++) begin : g_lane
        localparam pi_pos_t DST = pi_dest(x, y);
        assign pi_lane[DST.row][DST.elem] = rotl(lanes_q[y][x] ^ d_q[x], RHO_OFFSET[x][y]);
      end
    end
  endgenerate

  always_comb begin
    pi_state = '0;
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < 5; i++) begin
        pi_state[j][i] = pi_lane[j][i];
      end
    end
  end

  state_t     out_state;
  logic [4:0] out_round;
  logic       out_valid;

  generate
    if (OUTPUT_BUFFER != 0) begin : g_out_buf
      state_t     ob_state_q, ob_state_d;
      logic [4:0] ob_round_q, ob_round_d;
      logic       ob_valid_q, ob_valid_d;

      always_comb begin
        ob_valid_d = valid_q;
        ob_state_d = ob_state_q;
        ob_round_d = ob_round_q;
        if (valid_q) begin
          ob_state_d = pi_state;
          ob_round_d = round_q;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ob_valid_q <= 1'b0;
          ob_state_q <= '0;
          ob_round_q <= '0;
        end else begin
          ob_valid_q <= ob_valid_d;
          ob_state_q <= ob_state_d;
          ob_round_q <= ob_round_d;
        end
      end

      assign out_state = ob_state_q;
      assign out_round = ob_round_q;
      assign out_valid = ob_valid_q;
    end else begin : g_out_pass
      assign out_state = pi_state;
      assign out_round = round_q;
      assign out_valid = valid_q;
    end
  endgenerate

  assign osa    = out_state[0];
  assign osb    = out_state[1];
  assign osc    = out_state[2];
  assign osd    = out_state[3];
  assign ose    = out_state[4];
  assign oround = out_round;
  assign ogood  = out_valid;

endmodule

`default_nettype wire
